// File: rtl/iomem_router_pkg.sv
// Shared types, constants and address decode for the iomem peripheral router.
package iomem_router_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef enum logic [1:0] {DEC_SLOT, DEC_STAT, DEC_NONE} dec_kind_e;

    typedef struct packed {
        dec_kind_e  kind;
        logic [2:0] idx;
    } dec_t;

    localparam logic [3:0]  STAT_OFS_FLAGS    = 4'h0;
    localparam logic [3:0]  STAT_OFS_ADDR     = 4'h4;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Distance from the base byte picks slot/status/unmapped; 8-bit wrap keeps it unsigned-safe.
    function automatic dec_t decode_sel(input logic [7:0] sel, input logic [7:0] base,
                                        input int unsigned n);
        dec_t       d;
        logic [7:0] diff;
        diff   = sel - base;
        d.idx  = diff[2:0];
        if ({24'b0, diff} < n)       d.kind = DEC_SLOT;
        else if ({24'b0, diff} == n) d.kind = DEC_STAT;
        else                         d.kind = DEC_NONE;
        return d;
    endfunction

endpackage

// File: rtl/iomem_router_if.sv
// Bus bundle between the iomem master, the router and the peripheral slots.
interface iomem_router_if #(parameter int NUM_SLOTS = 4);
    logic                      m_valid;
    logic [31:0]               m_addr;
    logic [31:0]               m_wdata;
    logic [3:0]                m_wstrb;
    logic                      m_ready;
    logic [31:0]               m_rdata;
    logic [NUM_SLOTS-1:0]      s_valid;
    logic [31:0]               s_addr;
    logic [31:0]               s_wdata;
    logic [3:0]                s_wstrb;
    logic [NUM_SLOTS-1:0]      s_ready;
    logic [32*NUM_SLOTS-1:0]   s_rdata;

    // master: the CPU plus peripherals around the router; slave: the router itself
    modport master (output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
                    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb);
    modport slave  (input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
                    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb);
endinterface

// File: rtl/iomem_router_watchdog.sv
// Access watchdog: counts held cycles and flags the last allowed one.
module iomem_watchdog #(parameter int TIMEOUT_CYCLES = 255) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = 8'd0;
        else if (en) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/iomem_router.sv
// Routes iomem accesses to one-hot peripheral slots with a timeout and fault status register.
module iomem_router
    import iomem_router_pkg::*;
#(
    parameter int          NUM_SLOTS      = 4,
    parameter logic [7:0]  BASE_SEL       = 8'h03,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    iomem_router_if.slave  bus,
    output logic           err_irq
);
    state_e               state_q, state_d;
    logic [NUM_SLOTS-1:0] s_valid_q, s_valid_d;
    logic [31:0]          s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic [3:0]           s_wstrb_q, s_wstrb_d;
    logic [31:0]          m_rdata_q, m_rdata_d;
    logic                 err_flag_q, err_flag_d, err_irq_q, err_irq_d;
    logic [7:0]           err_count_q, err_count_d;
    logic [31:0]          last_err_addr_q, last_err_addr_d;
    logic                 wd_clr, wd_en, wd_expire, slot_ack;
    logic [31:0]          slot_rdata;
    logic [3:0]           stat_ofs;
    dec_t                 dec;

    iomem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk(clk), .reset(reset), .clr(wd_clr), .en(wd_en), .expire(wd_expire)
    );

    // s_valid_q is one-hot, so it doubles as the response mux select
    always_comb begin
        slot_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (s_valid_q[i]) slot_rdata = bus.s_rdata[i*32 +: 32];
        slot_ack = |(bus.s_ready & s_valid_q);
    end

    always_comb begin
        state_d         = state_q;
        s_valid_d       = s_valid_q;
        s_addr_d        = s_addr_q;
        s_wdata_d       = s_wdata_q;
        s_wstrb_d       = s_wstrb_q;
        m_rdata_d       = m_rdata_q;
        err_flag_d      = err_flag_q;
        err_count_d     = err_count_q;
        last_err_addr_d = last_err_addr_q;
        err_irq_d       = 1'b0;
        wd_clr          = 1'b0;
        wd_en           = 1'b0;
        dec             = decode_sel(bus.m_addr[31:24], BASE_SEL, NUM_SLOTS);
        stat_ofs        = {bus.m_addr[3:2], 2'b00};
        case (state_q)
            IDLE: if (bus.m_valid) begin
                s_addr_d  = bus.m_addr;
                s_wdata_d = bus.m_wdata;
                s_wstrb_d = bus.m_wstrb;
                state_d   = RESP;
                case (dec.kind)
                    DEC_SLOT: begin
                        s_valid_d = NUM_SLOTS'(1) << dec.idx;
                        wd_clr    = 1'b1;
                        state_d   = ACCESS;
                    end
                    DEC_STAT: begin
                        if (bus.m_wstrb != 4'b0) begin
                            if (stat_ofs == STAT_OFS_FLAGS) begin
                                err_flag_d  = 1'b0;
                                err_count_d = 8'd0;
                            end
                        end else if (stat_ofs == STAT_OFS_FLAGS) begin
                            m_rdata_d = {16'b0, err_count_q, 7'b0, err_flag_q};
                        end else if (stat_ofs == STAT_OFS_ADDR) begin
                            m_rdata_d = last_err_addr_q;
                        end else begin
                            m_rdata_d = 32'b0;
                        end
                    end
                    default: if (bus.m_wstrb == 4'b0) m_rdata_d = 32'b0;
                endcase
            end
            ACCESS: begin
                wd_en = 1'b1;
                if (slot_ack) begin
                    m_rdata_d = slot_rdata;
                    s_valid_d = '0;
                    state_d   = RESP;
                end else if (wd_expire) begin
                    m_rdata_d       = ERR_RDATA;
                    s_valid_d       = '0;
                    err_flag_d      = 1'b1;
                    err_count_d     = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
                    last_err_addr_d = s_addr_q;
                    err_irq_d       = 1'b1;
                    state_d         = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            s_valid_q       <= '0;
            s_addr_q        <= '0;
            s_wdata_q       <= '0;
            s_wstrb_q       <= '0;
            m_rdata_q       <= '0;
            err_flag_q      <= 1'b0;
            err_count_q     <= 8'd0;
            last_err_addr_q <= '0;
            err_irq_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            s_valid_q       <= s_valid_d;
            s_addr_q        <= s_addr_d;
            s_wdata_q       <= s_wdata_d;
            s_wstrb_q       <= s_wstrb_d;
            m_rdata_q       <= m_rdata_d;
            err_flag_q      <= err_flag_d;
            err_count_q     <= err_count_d;
            last_err_addr_q <= last_err_addr_d;
            err_irq_q       <= err_irq_d;
        end
    end

    assign bus.m_ready = (state_q == RESP);
    assign bus.m_rdata = m_rdata_q;
    assign bus.s_valid = s_valid_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.s_wstrb = s_wstrb_q;
    assign err_irq     = err_irq_q;
endmodule

// File: tb/tb_iomem_router.sv
// Directed bench for iomem_router with a 16-cycle watchdog.
module tb_iomem_router;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_irq;
    int   total = 0;
    int   bad = 0;

    iomem_router_if #(.NUM_SLOTS(4)) bus();

    iomem_router #(.NUM_SLOTS(4), .BASE_SEL(8'h03), .TIMEOUT_CYCLES(16), .ERR_RDATA(32'hDEAD_BEEF))
        dut (.clk(clk), .reset(reset), .bus(bus), .err_irq(err_irq));

    always #5 clk = ~clk;

    // results of the last access
    logic [31:0] r_rdata, r_wdata_seen;
    logic [3:0]  r_sv_seen;
    logic        r_addr_stable;
    int          r_lat, r_sv_cycles, r_irqs;

    // ack_at = ACCESS cycle (1-based) in which s_ready[ack_slot] is raised; ack_slot<0 means never
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                              input int ack_slot, input int ack_at);
        r_rdata = 'x; r_wdata_seen = '0; r_sv_seen = '0; r_addr_stable = 1'b1;
        r_lat = -1; r_sv_cycles = 0; r_irqs = 0;
        @(negedge clk);
        bus.m_valid = 1'b1; bus.m_addr = addr; bus.m_wdata = wdata; bus.m_wstrb = wstrb;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) bus.m_valid = 1'b0;
            bus.s_ready = '0;
            if (err_irq) r_irqs++;
            if (bus.s_valid != 4'b0) begin
                r_sv_cycles++;
                r_sv_seen |= bus.s_valid;
                if (bus.s_addr !== addr) r_addr_stable = 1'b0;
                r_wdata_seen = bus.s_wdata;
                if (ack_slot >= 0 && r_sv_cycles == ack_at) bus.s_ready[ack_slot] = 1'b1;
            end
            if (bus.m_ready) begin
                r_rdata = bus.m_rdata;
                r_lat = c;
                break;
            end
        end
        bus.s_ready = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (bus.m_ready !== 1'b0 || bus.m_rdata !== 32'h0 || bus.s_valid !== 4'h0 || bus.s_addr !== 32'h0 ||
            bus.s_wdata !== 32'h0 || bus.s_wstrb !== 4'h0 || err_irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: m_ready=%b m_rdata=%h s_valid=%b s_addr=%h s_wdata=%h s_wstrb=%h irq=%b, want all 0",
                     bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_addr, bus.s_wdata, bus.s_wstrb, err_irq);
        end
        reset = 1'b0;
        run_access(32'h0700_0000, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_rdata !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 00000000", r_rdata); end
    endtask

    task automatic test_write_slot0();
        run_access(32'h0300_0004, 32'h1234_5678, 4'hF, 0, 1);
        total++;
        if (r_sv_seen !== 4'b0001 || r_sv_cycles != 1) begin
            bad++; $display("FAIL wr0_svalid: seen=%b cycles=%0d want 0001/1", r_sv_seen, r_sv_cycles);
        end
        total++;
        if (r_wdata_seen !== 32'h1234_5678) begin bad++; $display("FAIL wr0_wdata: got %h want 12345678", r_wdata_seen); end
        total++;
        if (r_lat != 2 || r_irqs != 0) begin bad++; $display("FAIL wr0_latency: lat=%0d irqs=%0d want 2/0", r_lat, r_irqs); end
    endtask

    task automatic test_read_wait_slot1();
        bus.s_rdata[63:32] = 32'hCAFE_F00D;
        run_access(32'h0400_0000, 32'h0, 4'h0, 1, 6);
        total++;
        if (r_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rd1_data: got %h want cafef00d", r_rdata); end
        total++;
        if (r_lat != 7 || !r_addr_stable || r_sv_seen !== 4'b0010) begin
            bad++; $display("FAIL rd1_timing: lat=%0d stable=%b seen=%b want 7/1/0010", r_lat, r_addr_stable, r_sv_seen);
        end
        @(negedge clk);
        total++;
        if (bus.m_ready !== 1'b0 || bus.m_rdata !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL rd1_hold: m_ready=%b m_rdata=%h want 0/cafef00d", bus.m_ready, bus.m_rdata);
        end
    endtask

    task automatic test_unmapped();
        run_access(32'h0900_0000, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_lat != 1 || r_rdata !== 32'h0 || r_sv_cycles != 0) begin
            bad++; $display("FAIL unmapped_rd: lat=%0d rdata=%h sv=%0d want 1/0/0", r_lat, r_rdata, r_sv_cycles);
        end
        run_access(32'h0900_0000, 32'hFFFF_FFFF, 4'hF, -1, 0);
        total++;
        if (r_lat != 1 || r_sv_cycles != 0 || r_irqs != 0) begin
            bad++; $display("FAIL unmapped_wr: lat=%0d sv=%0d irqs=%0d want 1/0/0", r_lat, r_sv_cycles, r_irqs);
        end
        run_access(32'h0700_0000, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_rdata !== 32'h0) begin bad++; $display("FAIL unmapped_status: got %h want 00000000", r_rdata); end
    endtask

    task automatic test_timeout();
        run_access(32'h0500_0010, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_sv_cycles != 16 || r_sv_seen !== 4'b0100 || r_lat != 17) begin
            bad++; $display("FAIL to_svalid: cycles=%0d seen=%b lat=%0d want 16/0100/17", r_sv_cycles, r_sv_seen, r_lat);
        end
        total++;
        if (r_rdata !== 32'hDEAD_BEEF || r_irqs != 1) begin
            bad++; $display("FAIL to_resp: rdata=%h irqs=%0d want deadbeef/1", r_rdata, r_irqs);
        end
        @(negedge clk);
        total++;
        if (err_irq !== 1'b0) begin bad++; $display("FAIL to_irq_pulse: irq=%b want 0", err_irq); end
        run_access(32'h0700_0000, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_rdata !== 32'h0000_0101) begin bad++; $display("FAIL stat_flags: got %h want 00000101", r_rdata); end
        run_access(32'h0700_0004, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_rdata !== 32'h0500_0010) begin bad++; $display("FAIL stat_addr: got %h want 05000010", r_rdata); end
        run_access(32'h0700_0008, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_rdata !== 32'h0) begin bad++; $display("FAIL stat_other: got %h want 00000000", r_rdata); end
        run_access(32'h0700_0000, 32'h0, 4'h1, -1, 0);
        run_access(32'h0700_0000, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_rdata !== 32'h0) begin bad++; $display("FAIL stat_clear: got %h want 00000000", r_rdata); end
    endtask

    task automatic test_ready_at_timeout();
        bus.s_rdata[127:96] = 32'h0000_0042;
        run_access(32'h0600_0000, 32'h0, 4'h0, 3, 16);
        total++;
        if (r_rdata !== 32'h0000_0042 || r_irqs != 0 || r_lat != 17) begin
            bad++; $display("FAIL late_ready: rdata=%h irqs=%0d lat=%0d want 00000042/0/17", r_rdata, r_irqs, r_lat);
        end
        run_access(32'h0700_0000, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_rdata !== 32'h0) begin bad++; $display("FAIL late_ready_flag: got %h want 00000000", r_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int mr;
        run_access(32'h0500_0000, 32'h0, 4'h0, -1, 0);
        @(negedge clk);
        bus.m_valid = 1'b1; bus.m_addr = 32'h0300_0000; bus.m_wdata = 32'h0; bus.m_wstrb = 4'h0;
        @(negedge clk);
        bus.m_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.s_valid !== 4'b0001) begin bad++; $display("FAIL rst_mid_pre: s_valid=%b want 0001", bus.s_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (bus.s_valid !== 4'b0 || bus.m_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_drop: s_valid=%b m_ready=%b want 0/0", bus.s_valid, bus.m_ready);
        end
        mr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.m_ready) mr++;
        end
        total++;
        if (mr != 0) begin bad++; $display("FAIL rst_mid_noresp: m_ready pulses=%0d want 0", mr); end
        run_access(32'h0700_0000, 32'h0, 4'h0, -1, 0);
        total++;
        if (r_rdata !== 32'h0) begin bad++; $display("FAIL rst_mid_status: got %h want 00000000", r_rdata); end
    endtask

    initial begin
        bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
        bus.s_ready = '0; bus.s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_1000};
        repeat (2) @(negedge clk);
        test_reset();
        test_write_slot0();
        test_read_wait_slot1();
        test_unmapped();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
